sc_proc_elem_p: RTL and testbench

Parametrised serial-commutator FFT processing element: a radix-2 butterfly followed by an optional twiddle rotator, with configurable data/twiddle width, per-stage scaling, saturation with overflow flagging, and a valid/start-of-packet stream interface. One instance forms one stage of the SC FFT pipeline. Samples arrive as a single complex stream; consecutive valid beats are paired (a, b), and each pair yields y0 = a+b and y1 = (a−b)·W on two consecutive output beats.

---
 rtl/sc_proc_elem_p.sv | 210 +++++++++++++++++++++
 tb/tb_sc_proc_elem_p.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sc_proc_elem_p.sv
// rtl/sc_proc_elem_p.sv - serial-commutator radix-2 FFT processing element
// Pairs consecutive valid input beats (a, b) and emits y0 = a+b followed by
// y1 = (a-b)*W on the next cycle; y0 appears 3 cycles after the b beat.
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   in_valid, in_sop         input beat qualifier, frame start (forces an a beat)
//   in_re, in_im             input sample, signed DATA_W
//   tw_re, tw_im, tw_bypass  twiddle Q1.(TW_W-1) and rotation bypass, taken on b beats
//   out_valid, out_sop       output beat qualifier, first y0 of a frame
//   out_re, out_im, out_ovf  output sample and per-beat saturation flag
//   ovf_sticky               any out_ovf since reset
module sc_proc_elem_p #(
  parameter int DATA_W          = 16,
  parameter int TW_W            = 16,
  parameter int SCALE           = 1,
  parameter int INCLUDE_ROTATOR = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  input  logic signed [TW_W-1:0]   tw_re,
  input  logic signed [TW_W-1:0]   tw_im,
  input  logic                     tw_bypass,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     out_ovf,
  output logic                     ovf_sticky
);
  localparam int SW = DATA_W + 1;        // butterfly sum/difference width
  localparam int MW = DATA_W + TW_W;     // single product width
  localparam int PW = MW + 1;            // product sum width

  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [PW-1:0]     RND   = {{(PW-1){1'b0}}, 1'b1} << (TW_W - 2);

  // Returns {ovf, value}: halve with round-half-up, or saturate when unscaled.
  function automatic logic [DATA_W:0] cond_bfly(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] xp;
    xp = x + {{(SW-1){1'b0}}, 1'b1};
    if (SCALE != 0)
      cond_bfly = {1'b0, xp[SW-1:1]};
    else if (x[SW-1] != x[SW-2])
      cond_bfly = {1'b1, (x[SW-1] ? MIN_V : MAX_V)};
    else
      cond_bfly = {1'b0, x[DATA_W-1:0]};
  endfunction

  // Returns {ovf, value}: round, drop TW_W-1 fraction bits, saturate to DATA_W.
  function automatic logic [DATA_W:0] cond_rot(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = p + RND;
    // The shifted result fits when its bits above DATA_W-1 are all sign copies.
    if ((&r[PW-1:MW-2]) || !(|r[PW-1:MW-2]))
      cond_rot = {1'b0, r[MW-2:TW_W-1]};
    else
      cond_rot = {1'b1, (r[PW-1] ? MIN_V : MAX_V)};
  endfunction

  // ---------------- pairing ----------------
  logic                     parity_q, parity_d;   // 1: next valid beat is a b beat
  logic                     a_sop_q, a_sop_d;
  logic signed [DATA_W-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
  logic                     b_beat;

  always_comb begin
    parity_d = parity_q;
    a_sop_d  = a_sop_q;
    a_re_d   = a_re_q;
    a_im_d   = a_im_q;
    b_beat   = 1'b0;
    if (in_valid) begin
      // A new sop overwrites any pending a, which is thereby discarded.
      if (in_sop || !parity_q) begin
        parity_d = 1'b1;
        a_sop_d  = in_sop;
        a_re_d   = in_re;
        a_im_d   = in_im;
      end else begin
        parity_d = 1'b0;
        b_beat   = 1'b1;
      end
    end
  end

  // ---------------- stage 1: butterfly ----------------
  logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;
  logic [DATA_W:0]      cs_re, cs_im, cd_re, cd_im;

  assign sum_re = {a_re_q[DATA_W-1], a_re_q} + {in_re[DATA_W-1], in_re};
  assign sum_im = {a_im_q[DATA_W-1], a_im_q} + {in_im[DATA_W-1], in_im};
  assign dif_re = {a_re_q[DATA_W-1], a_re_q} - {in_re[DATA_W-1], in_re};
  assign dif_im = {a_im_q[DATA_W-1], a_im_q} - {in_im[DATA_W-1], in_im};
  assign cs_re  = cond_bfly(sum_re);
  assign cs_im  = cond_bfly(sum_im);
  assign cd_re  = cond_bfly(dif_re);
  assign cd_im  = cond_bfly(dif_im);

  logic                     v1_q, sop1_q, ovf_s1_q, ovf_d1_q, byp1_q;
  logic signed [DATA_W-1:0] s_re1_q, s_im1_q, d_re1_q, d_im1_q;
  logic signed [TW_W-1:0]   twr1_q, twi1_q;

  // ---------------- stage 2: complex multiply ----------------
  logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [PW-1:0] prod_re, prod_im;

  assign m_rr = $signed({{TW_W{d_re1_q[DATA_W-1]}}, d_re1_q}) * $signed({{DATA_W{twr1_q[TW_W-1]}}, twr1_q});
  assign m_ii = $signed({{TW_W{d_im1_q[DATA_W-1]}}, d_im1_q}) * $signed({{DATA_W{twi1_q[TW_W-1]}}, twi1_q});
  assign m_ri = $signed({{TW_W{d_re1_q[DATA_W-1]}}, d_re1_q}) * $signed({{DATA_W{twi1_q[TW_W-1]}}, twi1_q});
  assign m_ir = $signed({{TW_W{d_im1_q[DATA_W-1]}}, d_im1_q}) * $signed({{DATA_W{twr1_q[TW_W-1]}}, twr1_q});
  assign prod_re = {m_rr[MW-1], m_rr} - {m_ii[MW-1], m_ii};
  assign prod_im = {m_ri[MW-1], m_ri} + {m_ir[MW-1], m_ir};

  logic                     v2_q, sop2_q, ovf_s2_q, ovf_d2_q, byp2_q;
  logic signed [DATA_W-1:0] s_re2_q, s_im2_q, d_re2_q, d_im2_q;
  logic signed [PW-1:0]     p_re2_q, p_im2_q;

  // ---------------- stage 3: round/saturate and output sequencing ----------------
  logic [DATA_W:0]          cr_re, cr_im;
  logic signed [DATA_W-1:0] y1_re, y1_im;
  logic                     y1_ovf;

  assign cr_re  = cond_rot(p_re2_q);
  assign cr_im  = cond_rot(p_im2_q);
  assign y1_re  = byp2_q ? d_re2_q : cr_re[DATA_W-1:0];
  assign y1_im  = byp2_q ? d_im2_q : cr_im[DATA_W-1:0];
  assign y1_ovf = ovf_d2_q | (!byp2_q & (cr_re[DATA_W] | cr_im[DATA_W]));

  logic                     out_valid_q, out_valid_d, out_sop_q, out_sop_d;
  logic                     out_ovf_q, out_ovf_d, sticky_q, sticky_d;
  logic signed [DATA_W-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic                     hold_v_q, hold_v_d, hold_ovf_q, hold_ovf_d;
  logic signed [DATA_W-1:0] hold_re_q, hold_re_d, hold_im_q, hold_im_d;

  always_comb begin
    out_valid_d = 1'b0;
    out_sop_d   = 1'b0;
    out_ovf_d   = 1'b0;
    out_re_d    = '0;
    out_im_d    = '0;
    hold_v_d    = 1'b0;
    hold_ovf_d  = hold_ovf_q;
    hold_re_d   = hold_re_q;
    hold_im_d   = hold_im_q;
    if (v2_q) begin
      out_valid_d = 1'b1;
      out_sop_d   = sop2_q;
      out_ovf_d   = ovf_s2_q;
      out_re_d    = s_re2_q;
      out_im_d    = s_im2_q;
      hold_v_d    = 1'b1;
      hold_ovf_d  = y1_ovf;
      hold_re_d   = y1_re;
      hold_im_d   = y1_im;
    end else if (hold_v_q) begin
      out_valid_d = 1'b1;
      out_ovf_d   = hold_ovf_q;
      out_re_d    = hold_re_q;
      out_im_d    = hold_im_q;
    end
    sticky_d = sticky_q | out_ovf_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;  a_sop_q <= 1'b0;  a_re_q <= '0;  a_im_q <= '0;
      v1_q <= 1'b0;  sop1_q <= 1'b0;  ovf_s1_q <= 1'b0;  ovf_d1_q <= 1'b0;  byp1_q <= 1'b0;
      s_re1_q <= '0;  s_im1_q <= '0;  d_re1_q <= '0;  d_im1_q <= '0;  twr1_q <= '0;  twi1_q <= '0;
      v2_q <= 1'b0;  sop2_q <= 1'b0;  ovf_s2_q <= 1'b0;  ovf_d2_q <= 1'b0;  byp2_q <= 1'b0;
      s_re2_q <= '0;  s_im2_q <= '0;  d_re2_q <= '0;  d_im2_q <= '0;  p_re2_q <= '0;  p_im2_q <= '0;
      out_valid_q <= 1'b0;  out_sop_q <= 1'b0;  out_ovf_q <= 1'b0;  out_re_q <= '0;  out_im_q <= '0;
      hold_v_q <= 1'b0;  hold_ovf_q <= 1'b0;  hold_re_q <= '0;  hold_im_q <= '0;  sticky_q <= 1'b0;
    end else begin
      parity_q <= parity_d;  a_sop_q <= a_sop_d;  a_re_q <= a_re_d;  a_im_q <= a_im_d;
      v1_q <= b_beat;
      if (b_beat) begin
        sop1_q   <= a_sop_q;
        s_re1_q  <= cs_re[DATA_W-1:0];  s_im1_q <= cs_im[DATA_W-1:0];
        d_re1_q  <= cd_re[DATA_W-1:0];  d_im1_q <= cd_im[DATA_W-1:0];
        ovf_s1_q <= cs_re[DATA_W] | cs_im[DATA_W];
        ovf_d1_q <= cd_re[DATA_W] | cd_im[DATA_W];
        twr1_q   <= tw_re;  twi1_q <= tw_im;
        byp1_q   <= tw_bypass || (INCLUDE_ROTATOR == 0);
      end
      v2_q <= v1_q;
      if (v1_q) begin
        sop2_q  <= sop1_q;  ovf_s2_q <= ovf_s1_q;  ovf_d2_q <= ovf_d1_q;  byp2_q <= byp1_q;
        s_re2_q <= s_re1_q;  s_im2_q <= s_im1_q;  d_re2_q <= d_re1_q;  d_im2_q <= d_im1_q;
        p_re2_q <= prod_re;  p_im2_q <= prod_im;
      end
      out_valid_q <= out_valid_d;  out_sop_q <= out_sop_d;  out_ovf_q <= out_ovf_d;
      out_re_q <= out_re_d;  out_im_q <= out_im_d;
      hold_v_q <= hold_v_d;  hold_ovf_q <= hold_ovf_d;  hold_re_q <= hold_re_d;  hold_im_q <= hold_im_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sop    = out_sop_q;
  assign out_re     = out_re_q;
  assign out_im     = out_im_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_sc_proc_elem_p.sv
// tb/tb_sc_proc_elem_p.sv - scoreboard bench for sc_proc_elem_p (SCALE=1 and SCALE=0 instances)
module tb_sc_proc_elem_p;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_sop = 1'b0, tw_bypass = 1'b0;
  logic signed [15:0] in_re = '0, in_im = '0, tw_re = '0, tw_im = '0;

  logic o1_valid, o1_sop, o1_ovf, o1_sticky;
  logic signed [15:0] o1_re, o1_im;
  logic o0_valid, o0_sop, o0_ovf, o0_sticky;
  logic signed [15:0] o0_re, o0_im;

  sc_proc_elem_p #(.DATA_W(16), .TW_W(16), .SCALE(1), .INCLUDE_ROTATOR(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_re(in_re), .in_im(in_im), .tw_re(tw_re), .tw_im(tw_im), .tw_bypass(tw_bypass),
    .out_valid(o1_valid), .out_sop(o1_sop), .out_re(o1_re), .out_im(o1_im),
    .out_ovf(o1_ovf), .ovf_sticky(o1_sticky));

  sc_proc_elem_p #(.DATA_W(16), .TW_W(16), .SCALE(0), .INCLUDE_ROTATOR(1)) u_s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_re(in_re), .in_im(in_im), .tw_re(tw_re), .tw_im(tw_im), .tw_bypass(tw_bypass),
    .out_valid(o0_valid), .out_sop(o0_sop), .out_re(o0_re), .out_im(o0_im),
    .out_ovf(o0_ovf), .ovf_sticky(o0_sticky));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                 cyc;
    logic               sop;
    logic               ovf;
    logic signed [15:0] re;
    logic signed [15:0] im;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic push(input int k, input int c, input logic s, input logic o, input int re, input int im);
    exp_t e;
    e.cyc = c; e.sop = s; e.ovf = o; e.re = re[15:0]; e.im = im[15:0];
    if (k == 1) q1.push_back(e);
    else        q0.push_back(e);
  endtask

  task automatic chk(input int k, input logic s, input logic o, input logic signed [15:0] re, input logic signed [15:0] im);
    exp_t e;
    n_vec++;
    if ((k == 1 && q1.size() == 0) || (k == 0 && q0.size() == 0)) begin
      n_err++;
      $display("FAIL unexpected_out scale=%0d cyc=%0d: got re=%0d im=%0d sop=%0b ovf=%0b, required no output", k, cyc, re, im, s, o);
      return;
    end
    if (k == 1) e = q1.pop_front();
    else        e = q0.pop_front();
    if (e.cyc != cyc || e.sop != s || e.ovf != o || e.re != re || e.im != im) begin
      n_err++;
      $display("FAIL beat scale=%0d: got cyc=%0d re=%0d im=%0d sop=%0b ovf=%0b, required cyc=%0d re=%0d im=%0d sop=%0b ovf=%0b",
               k, cyc, re, im, s, o, e.cyc, e.re, e.im, e.sop, e.ovf);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (o1_valid) chk(1, o1_sop, o1_ovf, o1_re, o1_im);
    if (o0_valid) chk(0, o0_sop, o0_ovf, o0_re, o0_im);
  end

  task automatic chk_zero(input string nm, input logic v, input logic s, input logic o, input logic st,
                          input logic signed [15:0] re, input logic signed [15:0] im);
    n_vec++;
    if (v || s || o || st || re != 0 || im != 0) begin
      n_err++;
      $display("FAIL %s: got valid=%0b sop=%0b ovf=%0b sticky=%0b re=%0d im=%0d, required all 0", nm, v, s, o, st, re, im);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0b, required %0b", nm, got, want);
    end
  endtask

  task automatic beat(input logic v, input logic s, input int re, input int im,
                      input int wr, input int wi, input logic byp, output int c);
    in_valid = v; in_sop = s;
    in_re = re[15:0]; in_im = im[15:0];
    tw_re = wr[15:0]; tw_im = wi[15:0]; tw_bypass = byp;
    c = cyc;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    int c;
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom, 1'($urandom), c);
  endtask

  // One (a, b) pair; p* are SCALE=1 expectations, q* are SCALE=0 expectations.
  task automatic apply_pair(input logic sop, input int gap, input int idl, input logic byp,
                            input int ar, input int ai, input int br, input int bi, input int wr, input int wi,
                            input int p0r, input int p0i, input int p1r, input int p1i, input logic po0, input logic po1,
                            input int q0r, input int q0i, input int q1r, input int q1i, input logic qo0, input logic qo1);
    int c;
    // Twiddle on the a beat is junk and must be ignored.
    beat(1'b1, sop, ar, ai, $urandom, $urandom, ~byp, c);
    idle(gap);
    beat(1'b1, 1'b0, br, bi, wr, wi, byp, c);
    push(1, c + 3, sop, po0, p0r, p0i);  push(1, c + 4, 1'b0, po1, p1r, p1i);
    push(0, c + 3, sop, qo0, q0r, q0i);  push(0, c + 4, 1'b0, qo1, q1r, q1i);
    idle(idl);
  endtask

  initial begin
    int c;
    #3;
    chk_zero("reset_s1", o1_valid, o1_sop, o1_ovf, o1_sticky, o1_re, o1_im);
    chk_zero("reset_s0", o0_valid, o0_sop, o0_ovf, o0_sticky, o0_re, o0_im);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // bypass
    apply_pair(1, 0, 3, 1, 1000, -2000, 200, 400, 0, 0,
               600, -800, 400, -1200, 0, 0,   1200, -1600, 800, -2400, 0, 0);
    // rotation by -j
    apply_pair(0, 0, 3, 0, 1000, 0, 0, 0, 0, -32768,
               500, 0, 0, -500, 0, 0,   1000, 0, 0, -1000, 0, 0);
    // rotation by ~(0.7071 + 0.7071j)
    apply_pair(0, 0, 3, 0, 1000, 0, 0, 0, 23170, 23170,
               500, 0, 354, 354, 0, 0,   1000, 0, 707, 707, 0, 0);
    // rounding, b three cycles after a
    apply_pair(0, 2, 3, 1, 3, -3, 0, 0, 0, 0,
               2, -1, 2, -1, 0, 0,   3, -3, 3, -3, 0, 0);

    // streaming: 4 back-to-back pairs, sop on beat 0 only
    apply_pair(1, 0, 0, 1, 10, 20, 30, 40, 0, 0,
               20, 30, -10, -10, 0, 0,   40, 60, -20, -20, 0, 0);
    apply_pair(0, 0, 0, 1, -7, 5, 2, -4, 0, 0,
               -2, 1, -4, 5, 0, 0,   -5, 1, -9, 9, 0, 0);
    apply_pair(0, 0, 0, 0, 1000, 0, 0, 0, 23170, 23170,
               500, 0, 354, 354, 0, 0,   1000, 0, 707, 707, 0, 0);
    apply_pair(0, 0, 4, 1, 0, 0, 100, -100, 0, 0,
               50, -50, -50, 50, 0, 0,   100, -100, -100, 100, 0, 0);

    // realign: a pending sop beat is discarded by the next sop
    beat(1'b1, 1'b1, 9999, 9999, $urandom, $urandom, 1'b0, c);
    apply_pair(1, 0, 4, 1, 100, 100, 50, -50, 0, 0,
               75, 25, 25, 75, 0, 0,   150, 50, 50, 150, 0, 0);

    chk_bit("sticky_pre_sat_s1", o1_sticky, 1'b0);
    chk_bit("sticky_pre_sat_s0", o0_sticky, 1'b0);

    // saturation (only the SCALE=0 instance saturates)
    apply_pair(0, 0, 4, 1, 30000, -30000, 10000, 10000, 0, 0,
               20000, -10000, 10000, -20000, 0, 0,   32767, -20000, 20000, -32768, 1, 1);
    chk_bit("sticky_after_sat_s1", o1_sticky, 1'b0);
    chk_bit("sticky_after_sat_s0", o0_sticky, 1'b1);

    // a clean pair must not clear the sticky flag
    apply_pair(0, 0, 4, 1, 1000, -2000, 200, 400, 0, 0,
               600, -800, 400, -1200, 0, 0,   1200, -1600, 800, -2400, 0, 0);

    // reset between y0 and y1, with a lone a beat pending
    beat(1'b1, 1'b0, 1000, -2000, $urandom, $urandom, 1'b0, c);
    beat(1'b1, 1'b0, 200, 400, 0, 0, 1'b1, c);
    push(1, c + 3, 1'b0, 1'b0, 600, -800);
    push(0, c + 3, 1'b0, 1'b0, 1200, -1600);
    beat(1'b1, 1'b0, 777, 777, 0, 0, 1'b1, c);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    chk_bit("sticky_held_s0", o0_sticky, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset_s1", o1_valid, o1_sop, o1_ovf, o1_sticky, o1_re, o1_im);
    chk_zero("async_reset_s0", o0_valid, o0_sop, o0_ovf, o0_sticky, o0_re, o0_im);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // parity must restart at a: no sop on this pair
    apply_pair(0, 0, 6, 0, 1000, 0, 0, 0, 0, -32768,
               500, 0, 0, -500, 0, 0,   1000, 0, 0, -1000, 0, 0);

    n_vec++;
    if (q1.size() != 0) begin
      n_err++;
      $display("FAIL missing_out scale=1: got %0d outputs pending, required 0", q1.size());
    end
    n_vec++;
    if (q0.size() != 0) begin
      n_err++;
      $display("FAIL missing_out scale=0: got %0d outputs pending, required 0", q0.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
